// File: rtl/mips_timer.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, irq = irq_flag & IM.
// Writes land at posedge, reads are combinational; irq rises PRESET+2 cycles after EN is set.
module mips_timer #(
  parameter int ADDR_W = 2,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t            state;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       preset;
  logic [31:0]       count;
  logic              irqFlag;

  logic ctrlWr;
  logic presetWr;
  logic autoReload;

  assign ctrlWr     = we && (addr == ADDR_W'(0));
  assign presetWr   = we && (addr == ADDR_W'(1));
  assign autoReload = (ctrl[2:1] == 2'b01);

  // Statement order encodes priority: CPU CTRL write beats the FSM's EN clear,
  // and the FSM's irq_flag set beats the CPU-write clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
    end else begin
      if (ctrlWr || presetWr) irqFlag <= 1'b0;
      if (presetWr) preset <= din;

      case (state)
        IDLE: begin
          if (ctrl[0]) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count   <= '0;
            irqFlag <= 1'b1;
            state   <= INT;
          end
        end
        INT: begin
          if (autoReload) begin
            irqFlag <= 1'b0;
            state   <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (ctrlWr) ctrl <= din[CTRL_W-1:0];
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_W'(0): dout = {{(32-CTRL_W){1'b0}}, ctrl};
      ADDR_W'(1): dout = preset;
      ADDR_W'(2): dout = count;
      default:    dout = '0;
    endcase
  end

  assign irq = irqFlag & ctrl[3];

endmodule

// File: tb/tb_mips_timer.sv
// Bench for mips_timer: expected irq rise cycles are queued when the timer is programmed
// and popped when irq rises; register reads are compared against bench-computed values.
module tb_mips_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int expQ[$];
  logic irqPrev = 1'b0;
  int e0;
  int e1;

  mips_timer #(.ADDR_W(2), .CTRL_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Each irq rising edge must match the next queued cycle number.
  always @(negedge clk) begin
    if (irq && !irqPrev) begin
      if (expQ.size() > 0) check("irq_rise", 32'(cyc), 32'(expQ.pop_front()));
      else check("irq_spurious", 32'd1, 32'd0);
    end
    irqPrev = irq;
  end

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
  task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #12;
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset pulse mid-count
    wrReg(2'd1, 32'd40);
    wrReg(2'd0, 32'h9);
    e0 = cyc;
    waitUntil(e0 + 5);
    rd("mid_count", 2'd2, 32'd37);
    #1 reset = 1'b1;
    #1 check("midrst_irq", {31'b0, irq}, 32'd0);
    rd("midrst_ctrl", 2'd0, 32'h0);
    rd("midrst_preset", 2'd1, 32'h0);
    rd("midrst_count", 2'd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // One-shot, PRESET=5: irq after E0+7, held until CTRL write
    wrReg(2'd1, 32'd5);
    wrReg(2'd0, 32'h9);
    e0 = cyc;
    expQ.push_back(e0 + 7);
    waitUntil(e0 + 6);
    check("os_before", {31'b0, irq}, 32'd0);
    waitUntil(e0 + 7);
    check("os_rise", {31'b0, irq}, 32'd1);
    waitUntil(e0 + 10);
    rd("os_count", 2'd2, 32'd0);
    rd("os_ctrl", 2'd0, 32'h8);
    check("os_hold", {31'b0, irq}, 32'd1);
    wrReg(2'd0, 32'h0);
    check("os_clear", {31'b0, irq}, 32'd0);

    // Auto-reload PRESET=3 (period 5), then PRESET=6 mid-period (period 8 after next reload)
    wrReg(2'd1, 32'd3);
    wrReg(2'd0, 32'hB);
    e0 = cyc;
    expQ.push_back(e0 + 5);
    expQ.push_back(e0 + 10);
    expQ.push_back(e0 + 15);
    waitUntil(e0 + 5);
    check("ar_pulse", {31'b0, irq}, 32'd1);
    waitUntil(e0 + 6);
    check("ar_width", {31'b0, irq}, 32'd0);
    waitUntil(e0 + 17);
    wrReg(2'd1, 32'd6);
    expQ.push_back(e0 + 20);
    expQ.push_back(e0 + 28);
    expQ.push_back(e0 + 36);
    waitUntil(e0 + 37);
    check("ar_drained", 32'(expQ.size()), 32'd0);
    wrReg(2'd0, 32'h0);

    // IM=0: counts out silently; unmasking via a CTRL write also clears the flag
    wrReg(2'd1, 32'd10);
    wrReg(2'd0, 32'h1);
    e0 = cyc;
    waitUntil(e0 + 14);
    rd("im_count", 2'd2, 32'd0);
    rd("im_ctrl", 2'd0, 32'h0);
    check("im_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    wrReg(2'd0, 32'h8);
    check("im_unmask", {31'b0, irq}, 32'd0);
    rd("im_ctrl8", 2'd0, 32'h8);
    @(negedge clk);
    wrReg(2'd0, 32'h0);

    // Disable mid-count freezes COUNT; re-enable reloads from PRESET
    wrReg(2'd1, 32'd20);
    wrReg(2'd0, 32'h9);
    e0 = cyc;
    waitUntil(e0 + 5);
    rd("fr_run", 2'd2, 32'd17);
    wrReg(2'd0, 32'h0);
    waitUntil(e0 + 10);
    rd("fr_frozen", 2'd2, 32'd16);
    @(negedge clk);
    wrReg(2'd2, 32'hFFFF);
    rd("ro_count", 2'd2, 32'd16);
    wrReg(2'd3, 32'hDEAD);
    rd("rsvd_read", 2'd3, 32'h0);
    @(negedge clk);
    wrReg(2'd0, 32'h9);
    e1 = cyc;
    expQ.push_back(e1 + 22);
    waitUntil(e1 + 1);
    rd("re_before", 2'd2, 32'd16);
    waitUntil(e1 + 2);
    rd("re_reload", 2'd2, 32'd20);
    waitUntil(e1 + 23);
    wrReg(2'd0, 32'h0);

    // All-ones CTRL write: only 4 bits stick, MODE=11 runs as one-shot
    wrReg(2'd0, 32'hFFFF_FFFF);
    e0 = cyc;
    expQ.push_back(e0 + 22);
    rd("ctrl_all1", 2'd0, 32'hF);
    waitUntil(e0 + 24);
    rd("mode11_oneshot", 2'd0, 32'hE);
    check("mode11_irq", {31'b0, irq}, 32'd1);
    wrReg(2'd0, 32'h0);
    check("mode11_clear", {31'b0, irq}, 32'd0);

    // Simultaneous events: flag set beats PRESET write; CPU CTRL write beats EN clear
    wrReg(2'd1, 32'd2);
    wrReg(2'd0, 32'h9);
    e0 = cyc;
    expQ.push_back(e0 + 4);
    waitUntil(e0 + 3);
    wrReg(2'd1, 32'd2);
    check("set_wins", {31'b0, irq}, 32'd1);
    wrReg(2'd0, 32'h9);
    rd("cpu_wins", 2'd0, 32'h9);
    check("cpu_clr_flag", {31'b0, irq}, 32'd0);
    expQ.push_back(e0 + 9);
    waitUntil(e0 + 10);
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_irq", {31'b0, irq}, 32'd0);
    rd("rst_async_ctrl", 2'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("q_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
